inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Inverse of the decode tables: turns a symbolic instruction request (enc_op_t plus register/immediate fields)
//  into a 32-bit MIPS instruction word. Emits words on a valid/ready stream with sequential word addresses.
//  Sits between the test/boot-loader sequencer and instruction memory. Also feeds decoder round-trip checks.
// PARAMETERS
//  ADDR_W     32            width of inst_addr
//  BASE_ADDR  32'hBFC00000  address of first emitted word after reset/flush
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  flush        in   1       sync clear of pending words and address counter
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid & req_ready
//  req_op       in   enc_op_t symbolic operation
//  req_rs       in   5       rs field
//  req_rt       in   5       rt field
//  req_rd       in   5       rd field
//  req_shamt    in   5       shift amount
//  req_imm      in   32      immediate; I-type uses [15:0], LI uses all 32
//  req_target   in   26      J/JAL word target
//  inst_valid   out  1       inst_word valid
//  inst_ready   in   1       consumer takes word when inst_valid & inst_ready
//  inst_word    out  32      encoded instruction
//  inst_addr    out  ADDR_W  address of inst_word
//  err_illegal  out  1       1-cycle pulse: request op not encodable
// BEHAVIOUR
//  Reset: inst_valid=0, inst_word=0, inst_addr=BASE_ADDR, err_illegal=0, state=S_IDLE. req_ready is 0 in reset.
//  Latency: accepted request -> inst_valid next cycle. No combinational path from req_* to inst_*.
//  req_ready = !flush & state==S_IDLE & (!inst_valid | inst_ready). Full throughput with inst_ready=1.
//  Output register holds inst_word/inst_addr stable while inst_valid & !inst_ready.
//  inst_addr += 4 on each transfer (inst_valid & inst_ready). Wraps modulo 2^ADDR_W.
//  R-type: {6'b0,rs,rt,rd,shamt,funct}. SLL/SRL/SRA force rs=0; variable shifts and ALU ops force shamt=0.
//  JR: {0,rs,15'b0,6'b001000}. MFHI/MFLO: rd only. MTHI/MTLO: rs only. NOP=32'h0. SYNC=32'h0000000F.
//  I-type: {opcode,rs,rt,imm[15:0]}. LUI forces rs=0. BGTZ forces rt=0. J/JAL: {opcode,target}.
//  Illegal op (unlisted encoding, or LI without the macro): request is consumed and no word is emitted.
//    err_illegal pulses in the cycle after acceptance. The address does not advance.
//  FSM: S_IDLE (normal accept); S_LI_LO (second LI beat pending). The ORI beat enters the output register
//    on the transfer of the LUI beat; S_LI_LO -> S_IDLE on that load.
//  flush: inst_valid->0 and state->S_IDLE next cycle. inst_addr->BASE_ADDR. A concurrent request is not accepted.
//    A concurrent transfer still completes on the consumer side but does not advance inst_addr.
//  rst_n low mid-LI: the pending ORI beat is dropped and everything returns to reset values.
// CONFIGURATION
//  Macro MIPS_ENC_PSEUDO_LI_EN.
//  Defined: ENC_LI encodes a 32-bit load-immediate.
//    imm[31:16]==0 -> one ORI rt,$0,imm[15:0].
//    imm[15:0]==0 -> one LUI rt,imm[31:16].
//    Otherwise LUI rt,imm[31:16] then ORI rt,rt,imm[15:0] on consecutive addresses; req_ready=0 in S_LI_LO.
//  Undefined: S_LI_LO is not built. ENC_LI is illegal (err_illegal pulse).
// STRUCTURE
//  Package decode_table gains enc_op_t, an enum of every opcode_t/funct_t instruction plus ENC_NOP and ENC_LI.
//  It also gains enc_state_t {S_IDLE,S_LI_LO} and constant FUNCT_SYNC_WORD.
//  The encoder reuses opcode_t/funct_t values; no local encoding literals.
//  Sub-module inst_field_pack: pure-combinational enc_op_t+fields -> {word, illegal}. It is shared by both LI beats.
//  inst_encoder holds the FSM, output register and address counter.
// TESTING
//  1. ORI rs=1 rt=2 imm=0x1234 -> inst_word 0x34221234 at inst_addr 0xBFC00000, one cycle after accept.
//  2. SLL rd=3 rt=4 shamt=5, req_rs=7 -> 0x00041940 (rs forced 0); next word at 0xBFC00004.
//  3. ADDU rs=1 rt=2 rd=3, inst_ready low 3 cycles -> 0x00221821 held stable; req_ready=0 while held.
//  4. JAL target=0x0100000 -> 0x0C100000; J with the same target -> 0x08100000.
//  5. With the macro defined, LI rt=8 imm=0x12345678 -> 0x3C081234 then 0x35085678 at consecutive addrs.
//     req_ready=0 between them. LI imm=0x00005678 -> single 0x34085678.
//  6. Without the macro, LI -> err_illegal pulse, no inst_valid, addr unchanged.
//     With the macro, rst_n low during S_LI_LO -> no ORI word, inst_addr=0xBFC00000.

Source files
------------

// File: rtl/decode_table_pkg.sv
// decode_table: shared MIPS encoding tables.
//   opcode_t / funct_t : primary opcode and SPECIAL funct field values.
//   enc_op_t           : symbolic request for the instruction encoder; every
//                        opcode_t/funct_t instruction plus ENC_NOP and ENC_LI.
//   enc_state_t        : encoder sequencing state.
//   FUNCT_SYNC_WORD    : complete SYNC instruction word.
//   r_word/i_word/j_word : field assembly helpers for the three formats.
package decode_table;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
        OP_BNE     = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07, OP_ADDI = 6'h08,
        OP_ADDIU   = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
        OP_ORI     = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F, OP_LB   = 6'h20,
        OP_LH      = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24, OP_LHU  = 6'h25,
        OP_SB      = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
        FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_SYNC = 6'h0F,
        FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13,
        FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
        FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A, FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [5:0] {
        ENC_NOP = 6'd0, ENC_SLL, ENC_SRL, ENC_SRA, ENC_SLLV, ENC_SRLV, ENC_SRAV,
        ENC_JR, ENC_SYNC, ENC_MFHI, ENC_MTHI, ENC_MFLO, ENC_MTLO,
        ENC_ADD, ENC_ADDU, ENC_SUB, ENC_SUBU, ENC_AND, ENC_OR, ENC_XOR, ENC_NOR,
        ENC_SLT, ENC_SLTU, ENC_J, ENC_JAL, ENC_BEQ, ENC_BNE, ENC_BLEZ, ENC_BGTZ,
        ENC_ADDI, ENC_ADDIU, ENC_SLTI, ENC_SLTIU, ENC_ANDI, ENC_ORI, ENC_XORI,
        ENC_LUI, ENC_LB, ENC_LH, ENC_LW, ENC_LBU, ENC_LHU, ENC_SB, ENC_SH, ENC_SW,
        ENC_LI
    } enc_op_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_LI_LO = 1'b1
    } enc_state_t;

    localparam logic [31:0] FUNCT_SYNC_WORD = {26'd0, FN_SYNC};

    function automatic logic [31:0] r_word(input funct_t fn, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh);
        return {OP_SPECIAL, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input opcode_t op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input opcode_t op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/inst_encoder_field_pack.sv
// inst_field_pack: purely combinational symbolic-op to instruction-word packer.
//   op_i, rs_i, rt_i, rd_i, shamt_i, imm_i[15:0], target_i : request fields
//   word_o    : assembled 32-bit instruction (0 when illegal)
//   illegal_o : op_i has no encoding here (includes ENC_LI, which the
//               encoder splits into LUI/ORI before it reaches this block)
module inst_field_pack
    import decode_table::*;
(
    input  enc_op_t     op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Field assembly; fields a format does not use are forced to zero.
    always_comb begin
        word_o    = 32'd0;
        illegal_o = 1'b0;
        case (op_i)
            ENC_NOP:   word_o = 32'd0;
            ENC_SLL:   word_o = r_word(FN_SLL,  5'd0, rt_i, rd_i, shamt_i);
            ENC_SRL:   word_o = r_word(FN_SRL,  5'd0, rt_i, rd_i, shamt_i);
            ENC_SRA:   word_o = r_word(FN_SRA,  5'd0, rt_i, rd_i, shamt_i);
            ENC_SLLV:  word_o = r_word(FN_SLLV, rs_i, rt_i, rd_i, 5'd0);
            ENC_SRLV:  word_o = r_word(FN_SRLV, rs_i, rt_i, rd_i, 5'd0);
            ENC_SRAV:  word_o = r_word(FN_SRAV, rs_i, rt_i, rd_i, 5'd0);
            ENC_JR:    word_o = r_word(FN_JR,   rs_i, 5'd0, 5'd0, 5'd0);
            ENC_SYNC:  word_o = FUNCT_SYNC_WORD;
            ENC_MFHI:  word_o = r_word(FN_MFHI, 5'd0, 5'd0, rd_i, 5'd0);
            ENC_MTHI:  word_o = r_word(FN_MTHI, rs_i, 5'd0, 5'd0, 5'd0);
            ENC_MFLO:  word_o = r_word(FN_MFLO, 5'd0, 5'd0, rd_i, 5'd0);
            ENC_MTLO:  word_o = r_word(FN_MTLO, rs_i, 5'd0, 5'd0, 5'd0);
            ENC_ADD:   word_o = r_word(FN_ADD,  rs_i, rt_i, rd_i, 5'd0);
            ENC_ADDU:  word_o = r_word(FN_ADDU, rs_i, rt_i, rd_i, 5'd0);
            ENC_SUB:   word_o = r_word(FN_SUB,  rs_i, rt_i, rd_i, 5'd0);
            ENC_SUBU:  word_o = r_word(FN_SUBU, rs_i, rt_i, rd_i, 5'd0);
            ENC_AND:   word_o = r_word(FN_AND,  rs_i, rt_i, rd_i, 5'd0);
            ENC_OR:    word_o = r_word(FN_OR,   rs_i, rt_i, rd_i, 5'd0);
            ENC_XOR:   word_o = r_word(FN_XOR,  rs_i, rt_i, rd_i, 5'd0);
            ENC_NOR:   word_o = r_word(FN_NOR,  rs_i, rt_i, rd_i, 5'd0);
            ENC_SLT:   word_o = r_word(FN_SLT,  rs_i, rt_i, rd_i, 5'd0);
            ENC_SLTU:  word_o = r_word(FN_SLTU, rs_i, rt_i, rd_i, 5'd0);
            ENC_J:     word_o = j_word(OP_J,   target_i);
            ENC_JAL:   word_o = j_word(OP_JAL, target_i);
            ENC_BEQ:   word_o = i_word(OP_BEQ,   rs_i, rt_i, imm_i);
            ENC_BNE:   word_o = i_word(OP_BNE,   rs_i, rt_i, imm_i);
            ENC_BLEZ:  word_o = i_word(OP_BLEZ,  rs_i, rt_i, imm_i);
            ENC_BGTZ:  word_o = i_word(OP_BGTZ,  rs_i, 5'd0, imm_i);
            ENC_ADDI:  word_o = i_word(OP_ADDI,  rs_i, rt_i, imm_i);
            ENC_ADDIU: word_o = i_word(OP_ADDIU, rs_i, rt_i, imm_i);
            ENC_SLTI:  word_o = i_word(OP_SLTI,  rs_i, rt_i, imm_i);
            ENC_SLTIU: word_o = i_word(OP_SLTIU, rs_i, rt_i, imm_i);
            ENC_ANDI:  word_o = i_word(OP_ANDI,  rs_i, rt_i, imm_i);
            ENC_ORI:   word_o = i_word(OP_ORI,   rs_i, rt_i, imm_i);
            ENC_XORI:  word_o = i_word(OP_XORI,  rs_i, rt_i, imm_i);
            ENC_LUI:   word_o = i_word(OP_LUI,   5'd0, rt_i, imm_i);
            ENC_LB:    word_o = i_word(OP_LB,    rs_i, rt_i, imm_i);
            ENC_LH:    word_o = i_word(OP_LH,    rs_i, rt_i, imm_i);
            ENC_LW:    word_o = i_word(OP_LW,    rs_i, rt_i, imm_i);
            ENC_LBU:   word_o = i_word(OP_LBU,   rs_i, rt_i, imm_i);
            ENC_LHU:   word_o = i_word(OP_LHU,   rs_i, rt_i, imm_i);
            ENC_SB:    word_o = i_word(OP_SB,    rs_i, rt_i, imm_i);
            ENC_SH:    word_o = i_word(OP_SH,    rs_i, rt_i, imm_i);
            ENC_SW:    word_o = i_word(OP_SW,    rs_i, rt_i, imm_i);
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: symbolic instruction request -> MIPS word stream with addresses.
//   clk, rst_n (async, active low), flush (sync clear of output and address)
//   req_valid/req_ready + req_op, req_rs, req_rt, req_rd, req_shamt,
//     req_imm (I-type uses [15:0], LI all 32 bits), req_target : request side
//   inst_valid/inst_ready + inst_word, inst_addr : emitted word stream
//   err_illegal : one-cycle pulse after accepting a non-encodable request
// Optional feature: macro MIPS_ENC_PSEUDO_LI_EN enables ENC_LI (32-bit
// load-immediate as ORI, LUI, or LUI+ORI). Without it ENC_LI is illegal and
// the S_LI_LO state is never entered.
module inst_encoder
    import decode_table::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'hBFC0_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  enc_op_t           req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [31:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_word,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              err_illegal
);

    enc_state_t        state_q;
    logic              inst_valid_q;
    logic [31:0]       inst_word_q;
    logic [ADDR_W-1:0] inst_addr_q;
    logic              err_q;

    enc_op_t           pack_op_d;
    logic [4:0]        pack_rs_d;
    logic [15:0]       pack_imm_d;
    logic [31:0]       pack_word_s;
    logic              pack_illegal_s;
    logic              xfer_s;
    logic              accept_s;

`ifdef MIPS_ENC_PSEUDO_LI_EN
    logic              li_split_d;
    logic [4:0]        li_rt_q;
    logic [15:0]       li_lo_q;
`else
    logic              unused_imm_hi_s;
    assign unused_imm_hi_s = ^req_imm[31:16];
`endif

    // Gating on rst_n keeps req_ready low while reset is held.
    assign req_ready = rst_n & ~flush & (state_q == S_IDLE) & (~inst_valid_q | inst_ready);
    assign accept_s  = req_valid & req_ready;
    assign xfer_s    = inst_valid_q & inst_ready;

    // Select what the single packer encodes: the pending ORI beat, an LI
    // rewritten to LUI/ORI, or the request as presented.
    always_comb begin
        pack_op_d  = req_op;
        pack_rs_d  = req_rs;
        pack_imm_d = req_imm[15:0];
`ifdef MIPS_ENC_PSEUDO_LI_EN
        li_split_d = 1'b0;
        if (state_q == S_LI_LO) begin
            pack_op_d  = ENC_ORI;
            pack_rs_d  = li_rt_q;
            pack_imm_d = li_lo_q;
        end else if (req_op == ENC_LI) begin
            if (req_imm[31:16] == 16'd0) begin
                pack_op_d = ENC_ORI;
                pack_rs_d = 5'd0;
            end else begin
                pack_op_d  = ENC_LUI;
                pack_imm_d = req_imm[31:16];
                li_split_d = (req_imm[15:0] != 16'd0);
            end
        end else begin
            pack_op_d = req_op;
        end
`endif
    end

    // In S_LI_LO rt and the ORI source register are both the held li_rt_q.
    inst_field_pack u_field_pack (
        .op_i      (pack_op_d),
        .rs_i      (pack_rs_d),
`ifdef MIPS_ENC_PSEUDO_LI_EN
        .rt_i      ((state_q == S_LI_LO) ? li_rt_q : req_rt),
`else
        .rt_i      (req_rt),
`endif
        .rd_i      (req_rd),
        .shamt_i   (req_shamt),
        .imm_i     (pack_imm_d),
        .target_i  (req_target),
        .word_o    (pack_word_s),
        .illegal_o (pack_illegal_s)
    );

    // Sequencing FSM, output register and address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            inst_valid_q <= 1'b0;
            inst_word_q  <= 32'd0;
            inst_addr_q  <= BASE_ADDR;
            err_q        <= 1'b0;
`ifdef MIPS_ENC_PSEUDO_LI_EN
            li_rt_q      <= 5'd0;
            li_lo_q      <= 16'd0;
`endif
        end else if (flush) begin
            // A transfer in this cycle still completes at the consumer, but
            // the address restarts at BASE_ADDR rather than advancing.
            state_q      <= S_IDLE;
            inst_valid_q <= 1'b0;
            inst_addr_q  <= BASE_ADDR;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (xfer_s) begin
                inst_addr_q <= inst_addr_q + ADDR_W'(4);
            end
`ifdef MIPS_ENC_PSEUDO_LI_EN
            if (state_q == S_LI_LO) begin
                // The ORI beat replaces the LUI beat as the LUI is taken;
                // inst_valid stays high across both.
                if (xfer_s) begin
                    inst_word_q <= pack_word_s;
                    state_q     <= S_IDLE;
                end
            end else
`endif
            if (accept_s) begin
                if (pack_illegal_s) begin
                    inst_valid_q <= 1'b0;
                    err_q        <= 1'b1;
                end else begin
                    inst_valid_q <= 1'b1;
                    inst_word_q  <= pack_word_s;
`ifdef MIPS_ENC_PSEUDO_LI_EN
                    if (li_split_d) begin
                        state_q <= S_LI_LO;
                        li_rt_q <= req_rt;
                        li_lo_q <= req_imm[15:0];
                    end
`endif
                end
            end else if (xfer_s) begin
                inst_valid_q <= 1'b0;
            end
        end
    end

    assign inst_valid  = inst_valid_q;
    assign inst_word   = inst_word_q;
    assign inst_addr   = inst_addr_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
    import decode_table::*;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic        clk, rst_n, flush, req_valid, req_ready, inst_valid, inst_ready, err_illegal;
    enc_op_t     req_op;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [31:0] req_imm, inst_word, inst_addr;
    logic [25:0] req_target;

    int tests_run = 0;
    int tests_failed = 0;
    bit rdy_rand = 1'b0;
    bit rdy_manual = 1'b1;

    typedef struct packed { logic [31:0] w; logic [31:0] a; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] exp_addr = BASE;
    logic        err_exp = 1'b0;

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
        .req_imm(req_imm), .req_target(req_target), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_word(inst_word), .inst_addr(inst_addr), .err_illegal(err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoder: MIPS field rules written with literal opcode/funct numbers.
    function automatic logic [31:0] rf(input int fn, input logic [4:0] rs, rt, rd, sh);
        return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    endfunction
    function automatic logic [31:0] itf(input int opc, input logic [4:0] rs, rt, input logic [15:0] imm);
        return (32'(opc) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    endfunction

    function automatic void model(input enc_op_t op, input logic [4:0] rs, rt, rd, sh,
                                  input logic [31:0] imm, input logic [25:0] tg,
                                  output int n, output logic [31:0] w0, output logic [31:0] w1);
        logic [15:0] lo, hi;
        lo = imm[15:0]; hi = imm[31:16];
        n = 1; w0 = 32'd0; w1 = 32'd0;
        case (op)
            ENC_NOP:   w0 = 32'd0;
            ENC_SLL:   w0 = rf(0, 0, rt, rd, sh);
            ENC_SRL:   w0 = rf(2, 0, rt, rd, sh);
            ENC_SRA:   w0 = rf(3, 0, rt, rd, sh);
            ENC_SLLV:  w0 = rf(4, rs, rt, rd, 0);
            ENC_SRLV:  w0 = rf(6, rs, rt, rd, 0);
            ENC_SRAV:  w0 = rf(7, rs, rt, rd, 0);
            ENC_JR:    w0 = rf(8, rs, 0, 0, 0);
            ENC_SYNC:  w0 = 32'h0000_000F;
            ENC_MFHI:  w0 = rf(16, 0, 0, rd, 0);
            ENC_MTHI:  w0 = rf(17, rs, 0, 0, 0);
            ENC_MFLO:  w0 = rf(18, 0, 0, rd, 0);
            ENC_MTLO:  w0 = rf(19, rs, 0, 0, 0);
            ENC_ADD:   w0 = rf(32, rs, rt, rd, 0);
            ENC_ADDU:  w0 = rf(33, rs, rt, rd, 0);
            ENC_SUB:   w0 = rf(34, rs, rt, rd, 0);
            ENC_SUBU:  w0 = rf(35, rs, rt, rd, 0);
            ENC_AND:   w0 = rf(36, rs, rt, rd, 0);
            ENC_OR:    w0 = rf(37, rs, rt, rd, 0);
            ENC_XOR:   w0 = rf(38, rs, rt, rd, 0);
            ENC_NOR:   w0 = rf(39, rs, rt, rd, 0);
            ENC_SLT:   w0 = rf(42, rs, rt, rd, 0);
            ENC_SLTU:  w0 = rf(43, rs, rt, rd, 0);
            ENC_J:     w0 = (32'd2 << 26) | 32'(tg);
            ENC_JAL:   w0 = (32'd3 << 26) | 32'(tg);
            ENC_BEQ:   w0 = itf(4, rs, rt, lo);
            ENC_BNE:   w0 = itf(5, rs, rt, lo);
            ENC_BLEZ:  w0 = itf(6, rs, rt, lo);
            ENC_BGTZ:  w0 = itf(7, rs, 0, lo);
            ENC_ADDI:  w0 = itf(8, rs, rt, lo);
            ENC_ADDIU: w0 = itf(9, rs, rt, lo);
            ENC_SLTI:  w0 = itf(10, rs, rt, lo);
            ENC_SLTIU: w0 = itf(11, rs, rt, lo);
            ENC_ANDI:  w0 = itf(12, rs, rt, lo);
            ENC_ORI:   w0 = itf(13, rs, rt, lo);
            ENC_XORI:  w0 = itf(14, rs, rt, lo);
            ENC_LUI:   w0 = itf(15, 0, rt, lo);
            ENC_LB:    w0 = itf(32, rs, rt, lo);
            ENC_LH:    w0 = itf(33, rs, rt, lo);
            ENC_LW:    w0 = itf(35, rs, rt, lo);
            ENC_LBU:   w0 = itf(36, rs, rt, lo);
            ENC_LHU:   w0 = itf(37, rs, rt, lo);
            ENC_SB:    w0 = itf(40, rs, rt, lo);
            ENC_SH:    w0 = itf(41, rs, rt, lo);
            ENC_SW:    w0 = itf(43, rs, rt, lo);
`ifdef MIPS_ENC_PSEUDO_LI_EN
            ENC_LI: begin
                if (hi == 16'd0)      w0 = itf(13, 0, rt, lo);
                else if (lo == 16'd0) w0 = itf(15, 0, rt, hi);
                else begin n = 2; w0 = itf(15, 0, rt, hi); w1 = itf(13, rt, rt, lo); end
            end
`endif
            default:   n = 0;
        endcase
    endfunction

    // Scoreboard: checks transfers and err_illegal, predicts from accepted requests.
    always @(negedge clk) begin
        int n;
        logic [31:0] w0, w1;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete(); exp_addr = BASE; err_exp = 1'b0;
        end else begin
            chk("err_illegal", 32'(err_illegal), 32'(err_exp));
            err_exp = 1'b0;
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", inst_word, 32'hDEAD_DEAD);
                else begin
                    e = exp_q.pop_front();
                    chk("stream_word", inst_word, e.w);
                    chk("stream_addr", inst_addr, e.a);
                end
            end
            if (flush) begin
                exp_q.delete(); exp_addr = BASE;
            end else if (req_valid && req_ready) begin
                model(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target, n, w0, w1);
                if (n == 0) err_exp = 1'b1;
                if (n >= 1) begin exp_q.push_back('{w0, exp_addr}); exp_addr = exp_addr + 32'd4; end
                if (n == 2) begin exp_q.push_back('{w1, exp_addr}); exp_addr = exp_addr + 32'd4; end
            end
        end
    end

    // Consumer ready: random or manual.
    initial begin
        inst_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            inst_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_manual;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present a request until accepted; returns at posedge+1 after the accepting edge.
    task automatic send(input enc_op_t op, input logic [4:0] rs, rt, rd, sh,
                        input logic [31:0] imm, input logic [25:0] tg);
        bit done = 1'b0;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
        req_imm = imm; req_target = tg; req_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL accept_timeout: request op %0d never accepted", op);
        end
    endtask

    typedef struct {
        enc_op_t op; logic [4:0] rs, rt, rd, sh; logic [31:0] imm; logic [25:0] tg; logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    initial begin
        logic [31:0] a0;
        vecs[0]  = '{ENC_ORI,  5'd1,  5'd2,  5'd0, 5'd0, 32'h0000_1234, 26'd0, 32'h3422_1234};
        vecs[1]  = '{ENC_SLL,  5'd7,  5'd4,  5'd3, 5'd5, 32'd0, 26'd0, 32'h0004_1940};
        vecs[2]  = '{ENC_ADDU, 5'd1,  5'd2,  5'd3, 5'd9, 32'd0, 26'd0, 32'h0022_1821};
        vecs[3]  = '{ENC_JAL,  5'd0,  5'd0,  5'd0, 5'd0, 32'd0, 26'h010_0000, 32'h0C10_0000};
        vecs[4]  = '{ENC_J,    5'd0,  5'd0,  5'd0, 5'd0, 32'd0, 26'h010_0000, 32'h0810_0000};
        vecs[5]  = '{ENC_LUI,  5'd5,  5'd8,  5'd0, 5'd0, 32'h0000_ABCD, 26'd0, 32'h3C08_ABCD};
        vecs[6]  = '{ENC_BGTZ, 5'd3,  5'd9,  5'd0, 5'd0, 32'h0000_FFFC, 26'd0, 32'h1C60_FFFC};
        vecs[7]  = '{ENC_JR,   5'd31, 5'd1,  5'd2, 5'd3, 32'd0, 26'd0, 32'h03E0_0008};
        vecs[8]  = '{ENC_SYNC, 5'd1,  5'd2,  5'd3, 5'd4, 32'd0, 26'd0, 32'h0000_000F};
        vecs[9]  = '{ENC_MFHI, 5'd1,  5'd2,  5'd4, 5'd0, 32'd0, 26'd0, 32'h0000_2010};
        vecs[10] = '{ENC_NOP,  5'd9,  5'd9,  5'd9, 5'd9, 32'hFFFF_FFFF, 26'd5, 32'h0000_0000};
        vecs[11] = '{ENC_SW,   5'd29, 5'd31, 5'd0, 5'd0, 32'h0000_0010, 26'd0, 32'hAFBF_0010};

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = ENC_NOP;
        req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0; req_shamt = 5'd0; req_imm = 32'd0; req_target = 26'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_word", inst_word, 32'd0);
        chk("rst_inst_addr", inst_addr, BASE);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        tick(1);

        // Table-driven vectors, back to back with the consumer always ready.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tg);
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'd1);
            chk($sformatf("vec%0d_word", i), inst_word, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), inst_addr, BASE + 32'(4 * i));
        end
        tick(2);

        // Back-pressure: word held stable, no new request accepted.
        rdy_manual = 1'b0; tick(1);
        send(ENC_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 26'd0);
        a0 = BASE + 32'd48;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_word", inst_word, 32'h0022_1821);
            chk("stall_addr", inst_addr, a0);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1; rdy_manual = 1'b1;
        tick(2);

        // Illegal op: consumed, err pulse, no word, address unchanged.
        a0 = exp_addr;
        send(enc_op_t'(6'd50), 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 26'd0);
        chk("illegal_err", 32'(err_illegal), 32'd1);
        chk("illegal_valid", 32'(inst_valid), 32'd0);
        tick(1);
        chk("illegal_err_clear", 32'(err_illegal), 32'd0);
`ifndef MIPS_ENC_PSEUDO_LI_EN
        send(ENC_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678, 26'd0);
        chk("li_off_err", 32'(err_illegal), 32'd1);
        chk("li_off_valid", 32'(inst_valid), 32'd0);
        tick(1);
`endif
        send(ENC_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 32'h0000_00AA, 26'd0);
        chk("after_illegal_addr", inst_addr, a0);
        tick(2);

`ifdef MIPS_ENC_PSEUDO_LI_EN
        // LI split into LUI then ORI at consecutive addresses.
        a0 = exp_addr;
        send(ENC_LI, 5'd3, 5'd8, 5'd0, 5'd0, 32'h1234_5678, 26'd0);
        chk("li_lui_word", inst_word, 32'h3C08_1234);
        chk("li_lui_addr", inst_addr, a0);
        chk("li_mid_req_ready", 32'(req_ready), 32'd0);
        tick(1);
        chk("li_ori_word", inst_word, 32'h3508_5678);
        chk("li_ori_addr", inst_addr, a0 + 32'd4);
        tick(2);
        send(ENC_LI, 5'd3, 5'd8, 5'd0, 5'd0, 32'h0000_5678, 26'd0);
        chk("li_lo_word", inst_word, 32'h3408_5678);
        tick(1);
        chk("li_lo_single", 32'(inst_valid), 32'd0);
        send(ENC_LI, 5'd3, 5'd8, 5'd0, 5'd0, 32'hABCD_0000, 26'd0);
        chk("li_hi_word", inst_word, 32'h3C08_ABCD);
        tick(2);

        // Reset during S_LI_LO drops the ORI beat.
        rdy_manual = 1'b0; tick(1);
        send(ENC_LI, 5'd0, 5'd9, 5'd0, 5'd0, 32'h1111_2222, 26'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("li_rst_valid", 32'(inst_valid), 32'd0);
        chk("li_rst_addr", inst_addr, BASE);
        @(posedge clk); #1; rst_n = 1'b1; rdy_manual = 1'b1;
        tick(3);
        chk("li_rst_no_ori", 32'(inst_valid), 32'd0);
        chk("li_rst_addr2", inst_addr, BASE);
`endif

        // Flush while a word is held; concurrent request refused.
        rdy_manual = 1'b0; tick(1);
        send(ENC_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0001, 26'd0);
        flush = 1'b1; req_valid = 1'b1; req_op = ENC_ADDU;
        @(negedge clk);
        chk("flush_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1; flush = 1'b0; req_valid = 1'b0;
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("flush_addr", inst_addr, BASE);
        rdy_manual = 1'b1; tick(1);
        send(ENC_ORI, 5'd0, 5'd3, 5'd0, 5'd0, 32'h0000_0055, 26'd0);
        chk("post_flush_word", inst_word, 32'h3403_0055);
        chk("post_flush_addr", inst_addr, BASE);
        // Flush concurrent with a transfer: word delivered, address back to base.
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_xfer_valid", 32'(inst_valid), 32'd0);
        chk("flush_xfer_addr", inst_addr, BASE);
        tick(1);

        // Randomized stream against the reference model.
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                flush = 1'b1; tick(1); flush = 1'b0;
            end
            send(enc_op_t'(6'($urandom_range(0, 50))), 5'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), ($urandom_range(0, 3) == 0) ? {16'd0, 16'($urandom)} : $urandom,
                 26'($urandom));
            if ($urandom_range(0, 3) == 0) tick(1);
        end
        rdy_rand = 1'b0; rdy_manual = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || inst_valid); i++) tick(1);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
